// File: rtl/shift_add_multiplier.sv
// Iterative shift-and-add unsigned multiplier: P = A*B over W RUN cycles,
// with a start/busy/done handshake and a product register held until the next start.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; A/B captured on the accepting edge
// RUN   | one partial-product step per cycle, W cycles in total
// DONE  | one-cycle done pulse; P already holds the new product
module shift_add_multiplier #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] P
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t         state;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplr;
  logic [CW-1:0]  count;
  logic [2*W-1:0] acc_sum;

  // The final step's add is folded into P, so the product lands on the RUN->DONE edge.
  always_comb begin
    acc_sum = acc;
    if (mplr[0]) acc_sum = acc + mcand;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      P     <= '0;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= {{W{1'b0}}, A};
            mplr  <= B;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= acc_sum;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          count <= count + CW'(1);
          if (count == LAST) begin
            P     <= acc_sum;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (W=4): directed handshake cases
// plus all 256 operand pairs in random order against an arithmetic reference.
module tb_shift_add_multiplier;

  localparam int W = 4;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*W-1:0] P;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;

  shift_add_multiplier #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation with exact cycle-by-cycle handshake checks.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int exp_p;
    exp_p = int'(a) * int'(b);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy0"}, busy, 1);
    chk({tag, "_done0"}, done, 0);
    for (int i = 1; i < W; i++) begin
      @(posedge clk); #1;
      chk({tag, "_busy_run"}, busy, 1);
      chk({tag, "_done_run"}, done, 0);
    end
    @(posedge clk); #1;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_p"}, P, exp_p);
    @(posedge clk); #1;
    chk({tag, "_done_fall"}, done, 0);
    chk({tag, "_p_hold"}, P, exp_p);
  endtask

  initial begin
    int idx[256];
    int base_done;
    int tmp;
    int j;
    bit seen;

    reset = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_p", P, 0);
    @(negedge clk); reset = 1'b1;

    // 1
    do_op(4'd5, 4'd3, "t1");
    @(posedge clk); #1;
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_p", P, 8'h0F);

    // 2
    do_op(4'hF, 4'hF, "t2a");
    do_op(4'h8, 4'h2, "t2b");
    do_op(4'h0, 4'hB, "t2c");

    // 3: operand changes and start during RUN are ignored
    @(negedge clk); A = 4'd6; B = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    A = 4'hF; B = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("t3_done", done, 1);
    chk("t3_p", P, 8'h2A);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("t3_no_second_busy", busy, 0);
      chk("t3_no_second_done", done, 0);
    end
    chk("t3_p_hold", P, 8'h2A);

    // 4: start held high -> back-to-back, done pulses W+2 apart
    @(negedge clk); A = 4'd2; B = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    chk("t4_busy_a", busy, 1);
    @(negedge clk); A = 4'd4; B = 4'd4;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    chk("t4_done_a", done, 1);
    chk("t4_p_a", P, 8'h06);
    @(posedge clk); #1;
    chk("t4_done_a_fall", done, 0);
    chk("t4_busy_gap", busy, 0);
    @(posedge clk); #1;
    chk("t4_busy_b", busy, 1);
    start = 1'b0;
    for (int i = 0; i < W - 1; i++) begin
      @(posedge clk); #1;
      chk("t4_done_b_early", done, 0);
    end
    @(posedge clk); #1;
    chk("t4_done_b", done, 1);
    chk("t4_p_b", P, 8'h10);
    @(posedge clk); #1;
    chk("t4_busy_after", busy, 0);

    // 5: asynchronous reset mid-RUN
    @(negedge clk); A = 4'd9; B = 4'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("t5_async_busy", busy, 0);
    chk("t5_async_done", done, 0);
    chk("t5_async_p", P, 0);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("t5_no_done", done, 0);
    end
    do_op(4'd9, 4'd9, "t5b");

    // 6: all pairs, shuffled, with noise on inputs while running
    for (int i = 0; i < 256; i++) idx[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = idx[i]; idx[i] = idx[j]; idx[j] = tmp;
    end
    base_done = done_cnt;
    for (int n = 0; n < 256; n++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = idx[n][7:4];
      b = idx[n][3:0];
      @(negedge clk); A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
        A = W'($urandom); B = W'($urandom); start = 1'($urandom);
        @(posedge clk); #1;
        if (done) seen = 1'b1;
      end
      start = 1'b0;
      chk("t6_done_seen", seen, 1);
      chk("t6_p", P, int'(a) * int'(b));
      repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    #1;
    chk("t6_done_count", done_cnt - base_done, 256);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
